// File: rtl/mem_rr_arbiter_if.sv
// Bundle between the core array (master side) and the round-robin memory arbiter (slave side).
// Per-port buses are packed [port][bit], bit-identical to the flat 32*N_PORTS layout.
interface mem_rr_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int ID_BITS = (N_PORTS > 1) ? $clog2(N_PORTS) : 1
);
  logic [N_PORTS-1:0]       req_valid;
  logic [N_PORTS-1:0][31:0] req_addr;
  logic [N_PORTS-1:0][31:0] req_wdata;
  logic [N_PORTS-1:0][3:0]  req_wstrb;
  logic [N_PORTS-1:0]       req_ready;
  logic [N_PORTS-1:0][31:0] req_rdata;
  logic                     mem_valid;
  logic [31:0]              mem_addr;
  logic [31:0]              mem_wdata;
  logic [3:0]               mem_wstrb;
  logic                     mem_ready;
  logic [31:0]              mem_rdata;
  logic [ID_BITS-1:0]       grant_id;
  logic [ID_BITS-1:0]       stat_sel;
  logic [31:0]              stat_count;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata, stat_sel,
    output req_ready, req_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb, grant_id, stat_count
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_wstrb, mem_ready, mem_rdata, stat_sel,
    input  req_ready, req_rdata, mem_valid, mem_addr, mem_wdata, mem_wstrb, grant_id, stat_count
  );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Work-conserving round-robin arbiter: N_PORTS native memory masters onto one slave, IDLE->BUS->RESP.
// Optional per-port grant counters with a registered readback port under `MEM_ARB_STATS_EN.
module mem_rr_arbiter #(
  parameter int N_PORTS = 4
) (
  input  logic            clk,
  input  logic            resetn,
  mem_rr_arbiter_if.slave bus
);
  localparam int ID_BITS = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                   state;
  logic [ID_BITS-1:0]       last_q, gnt_q, pick, cand;
  logic                     mem_valid_q;
  logic [31:0]              mem_addr_q, mem_wdata_q;
  logic [3:0]               mem_wstrb_q;
  logic [N_PORTS-1:0]       ready_q;
  logic [N_PORTS-1:0][31:0] rdata_q;

  // Scan last+N down to last+1 so the port closest after last is assigned last and wins.
  always_comb begin
    pick = '0;
    cand = '0;
    for (int i = N_PORTS; i >= 1; i--) begin
      cand = ID_BITS'((int'(last_q) + i) % N_PORTS);
      if (bus.req_valid[cand]) pick = cand;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= IDLE;
      last_q      <= ID_BITS'(N_PORTS - 1);
      gnt_q       <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      ready_q     <= '0;
      rdata_q     <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.req_valid) begin
          gnt_q       <= pick;
          mem_addr_q  <= bus.req_addr[pick];
          mem_wdata_q <= bus.req_wdata[pick];
          mem_wstrb_q <= bus.req_wstrb[pick];
          mem_valid_q <= 1'b1;
          state       <= BUS;
        end
        BUS: if (bus.mem_ready) begin
          rdata_q[gnt_q] <= bus.mem_rdata;
          ready_q[gnt_q] <= 1'b1;
          last_q         <= gnt_q;
          mem_valid_q    <= 1'b0;
          state          <= RESP;
        end
        RESP: begin
          ready_q <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.req_ready = ready_q;
  assign bus.req_rdata = rdata_q;
  assign bus.grant_id  = gnt_q;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] cnt [N_PORTS];
  logic [31:0] stat_q;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_cnt
    always_ff @(posedge clk) begin
      if (!resetn)
        cnt[p] <= '0;
      else if (state == BUS && bus.mem_ready && gnt_q == ID_BITS'(p) && cnt[p] != '1)
        cnt[p] <= cnt[p] + 32'd1;
    end
  end

  // Selects beyond N_PORTS-1 (non power-of-two port counts) read as zero.
  always_ff @(posedge clk) begin
    if (!resetn)
      stat_q <= '0;
    else
      stat_q <= (int'(bus.stat_sel) < N_PORTS) ? cnt[bus.stat_sel] : '0;
  end

  assign bus.stat_count = stat_q;
`else
  logic unused_stat_sel;
  assign unused_stat_sel = ^bus.stat_sel;
  assign bus.stat_count  = '0;
`endif
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Randomized bench for mem_rr_arbiter: transaction-level reference model plus directed scenarios.
module tb_mem_rr_arbiter;
  localparam int N   = 4;
  localparam int IDB = 2;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  mem_rr_arbiter_if #(.N_PORTS(N)) bus ();
  mem_rr_arbiter #(.N_PORTS(N)) dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

  int n_chk = 0, n_pass = 0, n_fail = 0, cyc = 0;

  // stimulus knobs
  logic [N-1:0] req_mask = '1;
  int           req_pct = 100, w_min = 0, w_max = 0, sel_fix = -1;
  bit           fix_en = 0;
  logic [31:0]  fix_addr, fix_wdata, fix_rdata;
  logic [3:0]   fix_wstrb;
  bit           rst_req = 1, rst_applied = 1;

  // reference model: one transaction described by decision cycle k0 and slave wait wt
  bit          busy = 0;
  int          k0, wt, gp, last_m = N - 1, sel_prev = 0;
  logic [31:0] x_addr, x_wdata, x_rdata;
  logic [3:0]  x_wstrb;
  logic [31:0] shadow [N];
  bit          shadow_ok [N];
  int unsigned cnt_m [N];
  int          rr_seen [N];
  int          glog_id [$], glog_cyc [$];
  logic        mv_prev = 1'b0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  function automatic int rr_pick(logic [N-1:0] v, int last);
    for (int i = 1; i <= N; i++) if (v[(last + i) % N]) return (last + i) % N;
    return 0;
  endfunction

  task automatic do_cycle();
    logic         exp_mv;
    logic [N-1:0] exp_rr;
    logic [31:0]  exp_st;
    bit           in_wait, rdy_now;
    @(negedge clk);
    cyc++;
    exp_rr = '0;
    if (bus.mem_valid && !mv_prev) begin
      glog_id.push_back(int'(bus.grant_id));
      glog_cyc.push_back(cyc);
    end
    mv_prev = bus.mem_valid;
    for (int p = 0; p < N; p++) if (bus.req_ready[p]) rr_seen[p]++;

    if (rst_applied) begin
      chk("rst_mem_valid", 32'(bus.mem_valid), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_mem_addr",  bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
      chk("rst_grant_id",  32'(bus.grant_id), 32'd0);
      chk("rst_stat",      bus.stat_count, 32'd0);
      for (int p = 0; p < N; p++) chk("rst_rdata", bus.req_rdata[p], 32'd0);
      busy = 0;
      last_m = N - 1;
      for (int p = 0; p < N; p++) begin
        shadow[p] = '0; shadow_ok[p] = 1; cnt_m[p] = 0;
      end
    end else begin
      exp_mv = busy && cyc >= k0 + 1 && cyc <= k0 + 1 + wt;
      if (busy && cyc == k0 + wt + 2) exp_rr[gp] = 1'b1;
      chk("mem_valid", 32'(bus.mem_valid), 32'(exp_mv));
      chk("req_ready", 32'(bus.req_ready), 32'(exp_rr));
      if (exp_mv) begin
        chk("grant_id",  32'(bus.grant_id), 32'(gp));
        chk("mem_addr",  bus.mem_addr, x_addr);
        chk("mem_wdata", bus.mem_wdata, x_wdata);
        chk("mem_wstrb", 32'(bus.mem_wstrb), 32'(x_wstrb));
      end
      if (exp_rr != 0) begin
        if (x_wstrb == 4'd0) begin shadow[gp] = x_rdata; shadow_ok[gp] = 1; end
        else shadow_ok[gp] = 0;
      end
      for (int p = 0; p < N; p++) if (shadow_ok[p]) chk("req_rdata", bus.req_rdata[p], shadow[p]);
`ifdef MEM_ARB_STATS_EN
      exp_st = cnt_m[sel_prev];
`else
      exp_st = 32'd0;
`endif
      chk("stat_count", bus.stat_count, exp_st);
      if (exp_rr != 0) begin
        bus.req_valid[gp] = 1'b0;
        if (cnt_m[gp] != 32'hFFFF_FFFF) cnt_m[gp]++;
        last_m = gp;
      end
      if (busy && cyc == k0 + wt + 3) busy = 0;
    end

    resetn = !rst_req;
    rst_applied = rst_req;
    if (rst_req) busy = 0;

    // masters: a pending request holds its fields; idle ports scramble theirs
    for (int p = 0; p < N; p++) begin
      if (!bus.req_valid[p]) begin
        bus.req_addr[p]  = $urandom;
        bus.req_wdata[p] = $urandom;
        bus.req_wstrb[p] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom);
        if (!exp_rr[p] && req_mask[p] && $urandom_range(99) < req_pct) begin
          bus.req_valid[p] = 1'b1;
          if (fix_en) begin
            bus.req_addr[p] = fix_addr; bus.req_wdata[p] = fix_wdata; bus.req_wstrb[p] = fix_wstrb;
          end
        end
      end
    end
    bus.stat_sel = (sel_fix >= 0) ? IDB'(sel_fix) : IDB'($urandom_range(N - 1));
    sel_prev = int'(bus.stat_sel);

    if (!rst_req && !busy && bus.req_valid != 0) begin
      gp = rr_pick(bus.req_valid, last_m);
      busy = 1;
      k0 = cyc;
      wt = int'($urandom_range(w_max, w_min));
      x_addr = bus.req_addr[gp]; x_wdata = bus.req_wdata[gp]; x_wstrb = bus.req_wstrb[gp];
      x_rdata = fix_en ? fix_rdata : $urandom;
    end

    // slave: junk mem_ready outside BUS must be ignored
    in_wait = busy && cyc >= k0 + 1 && cyc < k0 + 1 + wt;
    rdy_now = busy && cyc == k0 + 1 + wt;
    bus.mem_ready = rdy_now ? 1'b1 : (in_wait ? 1'b0 : 1'($urandom_range(1)));
    bus.mem_rdata = rdy_now ? x_rdata : $urandom;
  endtask

  task automatic drain();
    req_mask = '0;
    for (int i = 0; i < 200 && (busy || bus.req_valid != 0); i++) do_cycle();
    chk("drain_timeout", 32'(busy || bus.req_valid != 0), 32'd0);
    do_cycle();
  endtask

  task automatic do_reset();
    rst_req = 1; do_cycle();
    rst_req = 0; do_cycle();
  endtask

  initial begin
    int r, base, n0;
    bus.req_valid = '0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_wstrb = '0;
    bus.mem_ready = 1'b0; bus.mem_rdata = '0; bus.stat_sel = '0;
    for (int p = 0; p < N; p++) begin shadow[p] = '0; shadow_ok[p] = 1; cnt_m[p] = 0; rr_seen[p] = 0; end

    // all ports requesting, zero-wait slave: grants 0,1,2,3,0 every 3 cycles
    req_mask = 4'b1111; req_pct = 100; w_min = 0; w_max = 0;
    do_reset();
    r = cyc;
    glog_id.delete(); glog_cyc.delete();
    repeat (14) do_cycle();
    chk("rr4_count", 32'(glog_id.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < glog_id.size(); i++) begin
      chk("rr4_id",  32'(glog_id[i]), 32'(i % N));
      chk("rr4_cyc", 32'(glog_cyc[i] - r), 32'(1 + 3 * i));
    end
    drain();

    // port 2 read of 0x40, three wait cycles
    fix_en = 1; fix_addr = 32'h0000_0040; fix_wdata = 32'h0; fix_wstrb = 4'b0000; fix_rdata = 32'hDEAD_BEEF;
    w_min = 3; w_max = 3; req_mask = 4'b0100;
    base = rr_seen[2];
    do_cycle();
    r = cyc;
    for (int i = 0; i < 50 && rr_seen[2] == base; i++) do_cycle();
    chk("p2_ready_cyc", 32'(cyc - r), 32'd5);
    chk("p2_rdata", bus.req_rdata[2], 32'hDEAD_BEEF);
    drain();

    // last=3 then ports 0 and 2 request: wrap to 0 first, then 2
    fix_en = 0; w_min = 0; w_max = 2;
    req_mask = 4'b1000; do_cycle(); req_mask = '0;
    drain();
    glog_id.delete();
    req_mask = 4'b0101;
    for (int i = 0; i < 60 && glog_id.size() < 2; i++) do_cycle();
    chk("wrap_count", 32'(glog_id.size()), 32'd2);
    if (glog_id.size() >= 2) begin
      chk("wrap_first", 32'(glog_id[0]), 32'd0);
      chk("wrap_second", 32'(glog_id[1]), 32'd2);
    end
    drain();

    // port 1 write; model checks the latched fields on every BUS cycle
    fix_en = 1; fix_addr = 32'h1000_0000; fix_wdata = 32'h1234_5678; fix_wstrb = 4'b0011;
    w_min = 2; w_max = 4; req_mask = 4'b0010;
    base = rr_seen[1];
    for (int i = 0; i < 50 && rr_seen[1] < base + 2; i++) do_cycle();
    chk("p1_write_done", 32'(rr_seen[1] - base), 32'd2);
    fix_en = 0;
    drain();

    // five port-3 transactions, then read its counter
    do_reset();
    w_min = 0; w_max = 1; sel_fix = 3; req_mask = 4'b1000;
    base = rr_seen[3];
    for (int i = 0; i < 100 && rr_seen[3] < base + 5; i++) do_cycle();
    drain();
`ifdef MEM_ARB_STATS_EN
    chk("stat_p3", bus.stat_count, 32'd5);
`else
    chk("stat_p3", bus.stat_count, 32'd0);
`endif
    sel_fix = -1;

    // reset during BUS: abandoned, then port 0 granted first
    w_min = 4; w_max = 4; req_mask = 4'b1111; req_pct = 100;
    for (int i = 0; i < 50 && !(busy && cyc == k0); i++) do_cycle();
    chk("bus_reached", 32'(busy && cyc == k0), 32'd1);
    rst_req = 1; do_cycle();
    rst_req = 0; do_cycle();
    n0 = glog_id.size();
    repeat (2) do_cycle();
    chk("post_rst_grant", 32'(glog_id.size() > n0 ? glog_id[n0] : -1), 32'd0);
    drain();

    // random traffic
    w_min = 0; w_max = 3; req_mask = 4'b1111; req_pct = 30;
    repeat (3000) do_cycle();
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
